// File: rtl/pc_redirect_arbiter.sv
// Next-PC redirect arbiter: boot sequencing, trap/branch/jump priority,
// stalled-redirect latching with preemption, and pipeline flush strobes.
module pc_redirect_arbiter #(
  parameter logic [31:0] BOOT_VEC   = 32'h0000_0000,
  parameter int unsigned BOOT_DELAY = 4
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iTrap_req,
  input  logic [31:0] iTrap_vec,
  input  logic        iBr_req,
  input  logic [31:0] iBr_tgt,
  input  logic        iJmp_req,
  input  logic [31:0] iJmp_tgt,
  input  logic        iHz_stall,
  input  logic        iImem_ready,
  output logic        oPC_stall,
  output logic        oPC_ext_s,
  output logic [31:0] oPC_tgt,
  output logic        oFlush_if,
  output logic        oFlush_id,
  output logic        oPending,
  output logic        oMisalign,
  output logic [1:0]  oDbg_state
);

  // Handshake: a request is a level-valid held by its source; a redirect is
  // consumed only in a cycle where the fetch side is ready (S=0), else latched.
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_PEND = 2'd2} state_t;

  localparam logic [7:0] C_DELAY = 8'(BOOT_DELAY);
  localparam logic [1:0] PRI_NONE = 2'd3;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_pend_tgt, w_pend_tgt_nxt;
  logic [1:0]  r_pend_pri, w_pend_pri_nxt;

  logic        w_stall, w_any, w_better;
  logic [1:0]  w_win_pri, w_sel_pri;
  logic [31:0] w_win_tgt, w_sel_tgt;

  assign w_stall = iHz_stall | ~iImem_ready;
  assign w_any   = iTrap_req | iBr_req | iJmp_req;

  always_comb begin
    w_win_pri = 2'd2;
    w_win_tgt = iJmp_tgt;
    if (iTrap_req) begin
      w_win_pri = 2'd0;
      w_win_tgt = iTrap_vec;
    end else if (iBr_req) begin
      w_win_pri = 2'd1;
      w_win_tgt = iBr_tgt;
    end
  end

  // Lower priority number wins; an equal-priority newcomer never displaces.
  assign w_better  = w_any && (w_win_pri < r_pend_pri);
  assign w_sel_pri = w_better ? w_win_pri : r_pend_pri;
  assign w_sel_tgt = w_better ? w_win_tgt : r_pend_tgt;

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      r_state    <= ST_BOOT;
      r_cnt      <= 8'd0;
      r_pend_tgt <= 32'd0;
      r_pend_pri <= PRI_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_pend_pri <= w_pend_pri_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pend_pri_nxt = r_pend_pri;
    case (r_state)
      ST_BOOT: begin
        if (r_cnt < C_DELAY) w_cnt_nxt = r_cnt + 8'd1;
        else if (iImem_ready) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_any && w_stall) begin
          w_state_nxt    = ST_PEND;
          w_pend_tgt_nxt = w_win_tgt;
          w_pend_pri_nxt = w_win_pri;
        end
      end
      ST_PEND: begin
        if (!w_stall) begin
          w_state_nxt    = ST_RUN;
          w_pend_tgt_nxt = 32'd0;
          w_pend_pri_nxt = PRI_NONE;
        end else if (w_better) begin
          w_pend_tgt_nxt = w_win_tgt;
          w_pend_pri_nxt = w_win_pri;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_comb begin
    oPC_stall = 1'b0;
    oPC_ext_s = 1'b0;
    oPC_tgt   = 32'd0;
    oFlush_if = 1'b0;
    oFlush_id = 1'b0;
    oPending  = 1'b0;
    oMisalign = 1'b0;
    case (r_state)
      ST_BOOT: begin
        oPC_stall = 1'b1;
        if (r_cnt >= C_DELAY && iImem_ready) begin
          oPC_stall = 1'b0;
          oPC_ext_s = 1'b1;
          oPC_tgt   = {BOOT_VEC[31:2], 2'b00};
          oMisalign = |BOOT_VEC[1:0];
        end
      end
      ST_RUN: begin
        oPC_stall = w_stall;
        if (w_any) begin
          oFlush_if = 1'b1;
          oFlush_id = (w_win_pri != 2'd2);
          if (!w_stall) begin
            oPC_ext_s = 1'b1;
            oPC_tgt   = {w_win_tgt[31:2], 2'b00};
            oMisalign = |w_win_tgt[1:0];
          end
        end
      end
      ST_PEND: begin
        oPending  = 1'b1;
        oPC_stall = w_stall;
        if (!w_stall) begin
          oPC_ext_s = 1'b1;
          oPC_tgt   = {w_sel_tgt[31:2], 2'b00};
          oMisalign = |w_sel_tgt[1:0];
          oFlush_if = 1'b1;
          oFlush_id = (w_sel_pri != 2'd2);
        end else if (w_better) begin
          oFlush_if = 1'b1;
          oFlush_id = (w_win_pri != 2'd2);
        end
      end
      default: oPC_stall = 1'b1;
    endcase
  end

  assign oDbg_state = r_state;

endmodule

// File: tb/tb_pc_redirect_arbiter.sv
// Bench for pc_redirect_arbiter: directed plan steps followed by random traffic,
// every cycle compared against a request-list reference model and a PC model.
module tb_pc_redirect_arbiter;

  localparam logic [31:0] BOOT_VEC   = 32'h0000_0000;
  localparam int unsigned BOOT_DELAY = 4;

  logic        iClk, nRst;
  logic        iTrap_req, iBr_req, iJmp_req, iHz_stall, iImem_ready;
  logic [31:0] iTrap_vec, iBr_tgt, iJmp_tgt;
  logic        oPC_stall, oPC_ext_s, oFlush_if, oFlush_id, oPending, oMisalign;
  logic [31:0] oPC_tgt;
  logic [1:0]  oDbg_state;

  pc_redirect_arbiter #(.BOOT_VEC(BOOT_VEC), .BOOT_DELAY(BOOT_DELAY)) dut (
    .iClk(iClk), .nRst(nRst),
    .iTrap_req(iTrap_req), .iTrap_vec(iTrap_vec),
    .iBr_req(iBr_req), .iBr_tgt(iBr_tgt),
    .iJmp_req(iJmp_req), .iJmp_tgt(iJmp_tgt),
    .iHz_stall(iHz_stall), .iImem_ready(iImem_ready),
    .oPC_stall(oPC_stall), .oPC_ext_s(oPC_ext_s), .oPC_tgt(oPC_tgt),
    .oFlush_if(oFlush_if), .oFlush_id(oFlush_id),
    .oPending(oPending), .oMisalign(oMisalign), .oDbg_state(oDbg_state)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // Reference model: booting flag with remaining wait, optional pending source.
  bit          m_boot = 1;
  int          m_wait = BOOT_DELAY;
  bit          m_has_pend = 0;
  int          m_psrc = 3;
  logic [31:0] m_ptgt = 32'd0;

  logic        e_stall, e_ext, e_fif, e_fid, e_pend, e_mis;
  logic [31:0] e_tgt;
  bit          e_skip_flush;
  int          e_win;
  logic [31:0] e_win_tgt;

  logic [31:0] tb_pc = 32'd0;
  logic [31:0] exp_pc = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input bit t, input logic [31:0] tv, input bit b, input logic [31:0] bv,
                       input bit j, input logic [31:0] jv, input bit hz, input bit rdy);
    iTrap_req = t; iTrap_vec = tv;
    iBr_req = b;   iBr_tgt = bv;
    iJmp_req = j;  iJmp_tgt = jv;
    iHz_stall = hz; iImem_ready = rdy;
  endtask

  task automatic apply_to(input int src, input logic [31:0] t);
    e_ext = 1; e_tgt = {t[31:2], 2'b00}; e_mis = (t[1:0] != 2'b00);
    e_fif = 1; e_fid = (src < 2);
  endtask

  task automatic model_eval();
    bit          rq[3];
    logic [31:0] tg[3];
    bit          s;
    rq[0] = iTrap_req; rq[1] = iBr_req; rq[2] = iJmp_req;
    tg[0] = iTrap_vec; tg[1] = iBr_tgt; tg[2] = iJmp_tgt;
    s = iHz_stall || !iImem_ready;
    e_win = -1; e_win_tgt = 32'd0;
    for (int k = 2; k >= 0; k--) if (rq[k]) begin e_win = k; e_win_tgt = tg[k]; end
    e_stall = 0; e_ext = 0; e_tgt = 32'd0; e_fif = 0; e_fid = 0; e_pend = 0; e_mis = 0;
    e_skip_flush = 0;
    if (m_boot) begin
      e_stall = 1;
      if (m_wait == 0 && iImem_ready) begin
        e_stall = 0;
        apply_to(3, BOOT_VEC);
        e_fif = 0; e_fid = 0;
      end
    end else begin
      e_stall = s;
      e_pend = m_has_pend;
      if (m_has_pend) begin
        if (!s) begin
          if (e_win >= 0 && e_win < m_psrc) apply_to(e_win, e_win_tgt);
          else apply_to(m_psrc, m_ptgt);
        end else if (e_win >= 0 && e_win < m_psrc) begin
          e_skip_flush = 1;
        end
      end else if (e_win >= 0) begin
        if (!s) apply_to(e_win, e_win_tgt);
        else begin e_fif = 1; e_fid = (e_win < 2); end
      end
    end
  endtask

  task automatic model_commit();
    bit s;
    s = iHz_stall || !iImem_ready;
    if (!nRst) begin
      m_boot = 1; m_wait = BOOT_DELAY; m_has_pend = 0; m_psrc = 3;
    end else if (m_boot) begin
      if (m_wait > 0) m_wait--;
      else if (iImem_ready) m_boot = 0;
    end else if (m_has_pend) begin
      if (!s) begin m_has_pend = 0; m_psrc = 3; end
      else if (e_win >= 0 && e_win < m_psrc) begin m_psrc = e_win; m_ptgt = e_win_tgt; end
    end else if (e_win >= 0 && s) begin
      m_has_pend = 1; m_psrc = e_win; m_ptgt = e_win_tgt;
    end
  endtask

  task automatic run_cycle();
    logic [31:0] nxt_tb_pc, nxt_exp_pc;
    #1;
    model_eval();
    if (chk_en) begin
      check("pc_stall", oPC_stall, e_stall);
      check("pc_ext_s", oPC_ext_s, e_ext);
      check("pc_tgt", oPC_tgt, e_tgt);
      check("pending", oPending, e_pend);
      check("misalign", oMisalign, e_mis);
      if (!e_skip_flush) begin
        check("flush_if", oFlush_if, e_fif);
        check("flush_id", oFlush_id, e_fid);
      end
      check("pc", tb_pc, exp_pc);
    end
    nxt_tb_pc  = oPC_ext_s ? oPC_tgt : (oPC_stall ? tb_pc : tb_pc + 32'd4);
    nxt_exp_pc = e_ext ? e_tgt : (e_stall ? exp_pc : exp_pc + 32'd4);
    @(posedge iClk);
    model_commit();
    tb_pc  = nxt_tb_pc;
    exp_pc = nxt_exp_pc;
    #1;
  endtask

  initial begin
    nRst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    // Boot from reset with memory ready.
    run_cycle();
    chk_en = 1;
    run_cycle();
    nRst = 1'b1;
    repeat (BOOT_DELAY) run_cycle();
    run_cycle();
    repeat (2) run_cycle();
    check("boot_pc_seq", tb_pc, BOOT_VEC + 32'd8);

    // Boot with memory not ready at the load point.
    nRst = 1'b0;
    run_cycle();
    nRst = 1'b1;
    repeat (BOOT_DELAY) run_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) run_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    run_cycle();
    check("boot_deferred_pc", tb_pc, BOOT_VEC);
    run_cycle();

    // All three sources in one unstalled cycle.
    drive(1, 32'h100, 1, 32'h200, 1, 32'h300, 0, 1);
    run_cycle();
    check("prio_pc", tb_pc, 32'h100);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    run_cycle();

    // Stalled jump, preempted by branch, later jump ignored.
    drive(0, 0, 0, 0, 1, 32'h40, 1, 1);
    run_cycle();
    drive(0, 0, 1, 32'h80, 0, 0, 1, 1);
    run_cycle();
    drive(0, 0, 0, 0, 1, 32'hC0, 1, 1);
    run_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    run_cycle();
    check("preempt_pc", tb_pc, 32'h80);
    run_cycle();

    // Misaligned branch target.
    drive(0, 0, 1, 32'h1003, 0, 0, 0, 1);
    run_cycle();
    check("misalign_pc", tb_pc, 32'h1000);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    run_cycle();

    // Reset while a trap is pending.
    drive(1, 32'h100, 0, 0, 0, 0, 1, 1);
    run_cycle();
    nRst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    run_cycle();
    nRst = 1'b1;
    repeat (BOOT_DELAY) run_cycle();
    run_cycle();
    check("reset_pend_pc", tb_pc, BOOT_VEC);
    run_cycle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      nRst = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 5) == 0, $urandom(),
            $urandom_range(0, 4) == 0, $urandom(),
            $urandom_range(0, 3) == 0, $urandom(),
            $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0);
      run_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
